// File: rtl/combo_lock_seq_if.sv
// rtl/combo_lock_seq_if.sv - digit/strobe/status bundle between keypad side and combo_lock_seq
// Carries the prog strobe only when LOCKER_PROG_EN is defined.
interface combo_lock_seq_if #(
  parameter int DIGIT_W  = 4,
  parameter int MAX_FAIL = 3
);
  logic [DIGIT_W-1:0]             digit;
  logic                           enter;
  logic                           lock;
`ifdef LOCKER_PROG_EN
  logic                           prog;
`endif
  logic                           open;
  logic                           error;
  logic                           locked_out;
  logic [$clog2(MAX_FAIL+1)-1:0]  fail_count;

`ifdef LOCKER_PROG_EN
  modport master (output digit, enter, lock, prog, input open, error, locked_out, fail_count);
  modport slave  (input digit, enter, lock, prog, output open, error, locked_out, fail_count);
`else
  modport master (output digit, enter, lock, input open, error, locked_out, fail_count);
  modport slave  (input digit, enter, lock, output open, error, locked_out, fail_count);
`endif
endinterface

// File: rtl/combo_lock_seq.sv
// rtl/combo_lock_seq.sv - sequential combination lock with fail counting and timed lockout
// Optional code reprogramming while open is enabled by defining LOCKER_PROG_EN.
module combo_lock_seq #(
  parameter int                          DIGIT_W        = 4,
  parameter int                          N_DIGITS       = 4,
  parameter logic [DIGIT_W*N_DIGITS-1:0] SECRET         = 16'h1234,
  parameter int                          MAX_FAIL       = 3,
  parameter int                          LOCKOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  combo_lock_seq_if.slave bus
);
  localparam int CODE_W = DIGIT_W * N_DIGITS;
  localparam int IDX_W  = $clog2(N_DIGITS);
  localparam int FC_W   = $clog2(MAX_FAIL + 1);
  localparam int LC_W   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);
  localparam logic [FC_W-1:0]  FAIL_LIMIT = FC_W'(MAX_FAIL);
  localparam logic [LC_W-1:0]  LOCK_LOAD  = LC_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_OPEN, S_LOCKOUT} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic               r_mismatch, w_mismatch_nxt;
  logic               r_open, w_open_nxt;
  logic               r_error, w_error_nxt;
  logic               r_locked_out, w_locked_out_nxt;
  logic [FC_W-1:0]    r_fail_count, w_fail_count_nxt;
  logic [LC_W-1:0]    r_lock_cnt, w_lock_cnt_nxt;

  logic [CODE_W-1:0]  w_code;
  logic [DIGIT_W-1:0] w_code_digit;
  logic               w_digit_miss;
  logic [FC_W-1:0]    w_fail_inc;

`ifdef LOCKER_PROG_EN
  logic [CODE_W-1:0]  r_code, w_code_nxt;
  logic [CODE_W-1:0]  r_shadow, w_shadow_nxt;
  logic [IDX_W-1:0]   r_pcnt, w_pcnt_nxt;
  logic [CODE_W-1:0]  w_shift;

  assign w_code  = r_code;
  assign w_shift = {r_shadow[CODE_W-DIGIT_W-1:0], bus.digit};
`else
  assign w_code = SECRET;
`endif

  // Digit 0 is the most significant slice of the code, i.e. the first one entered.
  logic [DIGIT_W-1:0] w_digits [N_DIGITS];
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digits
    assign w_digits[g] = w_code[(N_DIGITS-1-g)*DIGIT_W +: DIGIT_W];
  end

  assign w_code_digit = w_digits[r_idx];
  assign w_digit_miss = (bus.digit != w_code_digit);
  assign w_fail_inc   = r_fail_count + FC_W'(1);

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_mismatch_nxt   = r_mismatch;
    w_open_nxt       = r_open;
    w_error_nxt      = r_error;
    w_locked_out_nxt = r_locked_out;
    w_fail_count_nxt = r_fail_count;
    w_lock_cnt_nxt   = r_lock_cnt;
`ifdef LOCKER_PROG_EN
    w_code_nxt       = r_code;
    w_shadow_nxt     = r_shadow;
    w_pcnt_nxt       = r_pcnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.enter) begin
          w_state_nxt    = S_ENTRY;
          w_idx_nxt      = IDX_W'(1);
          w_mismatch_nxt = w_digit_miss;
          w_error_nxt    = 1'b0;
        end
      end
      S_ENTRY: begin
        if (bus.enter) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt      = '0;
            w_mismatch_nxt = 1'b0;
            if (!(r_mismatch || w_digit_miss)) begin
              w_state_nxt      = S_OPEN;
              w_open_nxt       = 1'b1;
              w_error_nxt      = 1'b0;
              w_fail_count_nxt = '0;
            end else if (w_fail_inc == FAIL_LIMIT) begin
              w_state_nxt      = S_LOCKOUT;
              w_error_nxt      = 1'b1;
              w_locked_out_nxt = 1'b1;
              w_fail_count_nxt = FAIL_LIMIT;
              w_lock_cnt_nxt   = LOCK_LOAD;
            end else begin
              w_state_nxt      = S_IDLE;
              w_error_nxt      = 1'b1;
              w_fail_count_nxt = w_fail_inc;
            end
          end else begin
            w_idx_nxt      = r_idx + IDX_W'(1);
            w_mismatch_nxt = r_mismatch | w_digit_miss;
          end
        end
      end
      S_OPEN: begin
        // lock wins over a simultaneous strobe and drops any partial reprogramming
        if (bus.lock) begin
          w_state_nxt = S_IDLE;
          w_open_nxt  = 1'b0;
`ifdef LOCKER_PROG_EN
          w_pcnt_nxt  = '0;
        end else if (bus.prog && bus.enter) begin
          w_shadow_nxt = w_shift;
          if (r_pcnt == LAST_IDX) begin
            w_code_nxt = w_shift;
            w_pcnt_nxt = '0;
          end else begin
            w_pcnt_nxt = r_pcnt + IDX_W'(1);
          end
`endif
        end
      end
      S_LOCKOUT: begin
        if (r_lock_cnt == '0) begin
          w_state_nxt      = S_IDLE;
          w_locked_out_nxt = 1'b0;
          w_error_nxt      = 1'b0;
          w_fail_count_nxt = '0;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt - LC_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_mismatch   <= 1'b0;
      r_open       <= 1'b0;
      r_error      <= 1'b0;
      r_locked_out <= 1'b0;
      r_fail_count <= '0;
      r_lock_cnt   <= '0;
`ifdef LOCKER_PROG_EN
      r_code       <= SECRET;
      r_shadow     <= '0;
      r_pcnt       <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_mismatch   <= w_mismatch_nxt;
      r_open       <= w_open_nxt;
      r_error      <= w_error_nxt;
      r_locked_out <= w_locked_out_nxt;
      r_fail_count <= w_fail_count_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
`ifdef LOCKER_PROG_EN
      r_code       <= w_code_nxt;
      r_shadow     <= w_shadow_nxt;
      r_pcnt       <= w_pcnt_nxt;
`endif
    end
  end

  assign bus.open       = r_open;
  assign bus.error      = r_error;
  assign bus.locked_out = r_locked_out;
  assign bus.fail_count = r_fail_count;
endmodule

// File: tb/tb_combo_lock_seq.sv
// tb/tb_combo_lock_seq.sv - directed bench for combo_lock_seq (code 1234, 3 fails, 16-cycle lockout)
// Also exercises reprogramming when LOCKER_PROG_EN is defined.
module tb_combo_lock_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  combo_lock_seq_if #(.DIGIT_W(4), .MAX_FAIL(3)) bus ();

  combo_lock_seq #(
    .DIGIT_W(4), .N_DIGITS(4), .SECRET(16'h1234), .MAX_FAIL(3), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      bus.digit = code[15-4*i -: 4];
      bus.enter = 1'b1;
      tick();
    end
    bus.enter = 1'b0;
  endtask

  task automatic do_lock();
    bus.lock = 1'b1;
    tick();
    bus.lock = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (bus.open !== 1'b0) $display("FAIL reset_open: got %b want 0", bus.open); else n_pass++;
    n_checks++; if (bus.error !== 1'b0) $display("FAIL reset_error: got %b want 0", bus.error); else n_pass++;
    n_checks++; if (bus.locked_out !== 1'b0) $display("FAIL reset_locked_out: got %b want 0", bus.locked_out); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd0) $display("FAIL reset_fail_count: got %0d want 0", bus.fail_count); else n_pass++;
  endtask

  task automatic test_open();
    enter_code(16'h1234);
    n_checks++; if (bus.open !== 1'b1) $display("FAIL open_good_code: got %b want 1", bus.open); else n_pass++;
    n_checks++; if (bus.error !== 1'b0) $display("FAIL open_error: got %b want 0", bus.error); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd0) $display("FAIL open_fail_count: got %0d want 0", bus.fail_count); else n_pass++;
    bus.digit = 4'h9;
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    n_checks++; if (bus.open !== 1'b1) $display("FAIL open_ignores_enter: got %b want 1", bus.open); else n_pass++;
    do_lock();
    n_checks++; if (bus.open !== 1'b0) $display("FAIL lock_closes: got %b want 0", bus.open); else n_pass++;
  endtask

  task automatic test_wrong_code();
    bus.enter = 1'b1;
    bus.digit = 4'h1; tick();
    bus.digit = 4'h2; tick();
    bus.digit = 4'h9; tick();
    n_checks++; if (bus.error !== 1'b0) $display("FAIL wrong_no_early_error: got %b want 0", bus.error); else n_pass++;
    bus.digit = 4'h4; tick();
    bus.enter = 1'b0;
    n_checks++; if (bus.error !== 1'b1) $display("FAIL wrong_error: got %b want 1", bus.error); else n_pass++;
    n_checks++; if (bus.open !== 1'b0) $display("FAIL wrong_open: got %b want 0", bus.open); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd1) $display("FAIL wrong_fail_count: got %0d want 1", bus.fail_count); else n_pass++;
    bus.enter = 1'b1;
    bus.digit = 4'h1; tick();
    n_checks++; if (bus.error !== 1'b0) $display("FAIL wrong_error_clears: got %b want 0", bus.error); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd1) $display("FAIL wrong_fail_count_hold: got %0d want 1", bus.fail_count); else n_pass++;
    bus.digit = 4'h2; tick();
    bus.digit = 4'h3; tick();
    bus.digit = 4'h4; tick();
    bus.enter = 1'b0;
    n_checks++; if (bus.open !== 1'b1) $display("FAIL wrong_then_good_open: got %b want 1", bus.open); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd0) $display("FAIL wrong_then_good_fail_count: got %0d want 0", bus.fail_count); else n_pass++;
    do_lock();
  endtask

  task automatic test_lockout();
    int  cycles;
    logic saw_open;
    enter_code(16'h1294);
    enter_code(16'h5555);
    n_checks++; if (bus.fail_count !== 2'd2) $display("FAIL lockout_second_fail: got %0d want 2", bus.fail_count); else n_pass++;
    n_checks++; if (bus.locked_out !== 1'b0) $display("FAIL lockout_not_yet: got %b want 0", bus.locked_out); else n_pass++;
    enter_code(16'h4321);
    n_checks++; if (bus.locked_out !== 1'b1) $display("FAIL lockout_set: got %b want 1", bus.locked_out); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd3) $display("FAIL lockout_fail_count: got %0d want 3", bus.fail_count); else n_pass++;
    n_checks++; if (bus.error !== 1'b1) $display("FAIL lockout_error: got %b want 1", bus.error); else n_pass++;
    cycles = 1;
    saw_open = 1'b0;
    for (int i = 0; i < 40 && bus.locked_out === 1'b1; i++) begin
      bus.digit = 4'((i % 4) + 1);
      bus.enter = 1'b1;
      bus.lock  = (i % 3) == 0;
      tick();
      if (bus.locked_out === 1'b1) cycles++;
      if (bus.open !== 1'b0) saw_open = 1'b1;
    end
    bus.enter = 1'b0;
    bus.lock  = 1'b0;
    n_checks++; if (cycles !== 16) $display("FAIL lockout_duration: got %0d cycles want 16", cycles); else n_pass++;
    n_checks++; if (saw_open !== 1'b0) $display("FAIL lockout_ignores_code: open seen %b want 0", saw_open); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd0) $display("FAIL lockout_exit_fail_count: got %0d want 0", bus.fail_count); else n_pass++;
    n_checks++; if (bus.error !== 1'b0) $display("FAIL lockout_exit_error: got %b want 0", bus.error); else n_pass++;
    enter_code(16'h1234);
    n_checks++; if (bus.open !== 1'b1) $display("FAIL lockout_then_open: got %b want 1", bus.open); else n_pass++;
    do_lock();
  endtask

  task automatic test_reset_mid();
    bus.enter = 1'b1;
    bus.digit = 4'h1; tick();
    bus.digit = 4'h2; tick();
    bus.enter = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if ({bus.open, bus.error, bus.locked_out, bus.fail_count} !== 5'b0)
      $display("FAIL reset_mid_outputs: got %b want 00000", {bus.open, bus.error, bus.locked_out, bus.fail_count}); else n_pass++;
    enter_code(16'h1234);
    n_checks++; if (bus.open !== 1'b1) $display("FAIL reset_mid_then_open: got %b want 1", bus.open); else n_pass++;
    do_lock();
    enter_code(16'h0000);
    enter_code(16'h0000);
    enter_code(16'h0000);
    n_checks++; if (bus.locked_out !== 1'b1) $display("FAIL reset_lockout_setup: got %b want 1", bus.locked_out); else n_pass++;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (bus.locked_out !== 1'b0) $display("FAIL reset_in_lockout: got %b want 0", bus.locked_out); else n_pass++;
    n_checks++; if (bus.fail_count !== 2'd0) $display("FAIL reset_in_lockout_fail_count: got %0d want 0", bus.fail_count); else n_pass++;
  endtask

  task automatic test_lock_with_enter();
    bus.lock = 1'b1;
    tick();
    bus.lock = 1'b0;
    enter_code(16'h1234);
    n_checks++; if (bus.open !== 1'b1) $display("FAIL lock_in_idle_no_effect: got %b want 1", bus.open); else n_pass++;
    bus.lock  = 1'b1;
    bus.enter = 1'b1;
    bus.digit = 4'h1;
    tick();
    bus.lock  = 1'b0;
    bus.enter = 1'b0;
    n_checks++; if (bus.open !== 1'b0) $display("FAIL lock_enter_closes: got %b want 0", bus.open); else n_pass++;
    enter_code(16'h1234);
    n_checks++; if (bus.open !== 1'b1) $display("FAIL lock_enter_digit_discarded: got %b want 1", bus.open); else n_pass++;
    n_checks++; if (bus.error !== 1'b0) $display("FAIL lock_enter_no_error: got %b want 0", bus.error); else n_pass++;
    do_lock();
  endtask

`ifdef LOCKER_PROG_EN
  task automatic test_prog();
    enter_code(16'h1234);
    bus.prog = 1'b1;
    enter_code(16'h5678);
    bus.prog = 1'b0;
    n_checks++; if (bus.open !== 1'b1) $display("FAIL prog_stays_open: got %b want 1", bus.open); else n_pass++;
    do_lock();
    enter_code(16'h1234);
    n_checks++; if (bus.error !== 1'b1) $display("FAIL prog_old_code_rejected: got %b want 1", bus.error); else n_pass++;
    enter_code(16'h5678);
    n_checks++; if (bus.open !== 1'b1) $display("FAIL prog_new_code_opens: got %b want 1", bus.open); else n_pass++;
    do_lock();
    reset = 1'b1; tick(); reset = 1'b0;
    enter_code(16'h1234);
    n_checks++; if (bus.open !== 1'b1) $display("FAIL prog_reset_restores_secret: got %b want 1", bus.open); else n_pass++;
    do_lock();
  endtask
`endif

  initial begin
    reset     = 1'b1;
    bus.digit = '0;
    bus.enter = 1'b0;
    bus.lock  = 1'b0;
`ifdef LOCKER_PROG_EN
    bus.prog  = 1'b0;
`endif
    tick();
    test_reset();
    test_open();
    test_wrong_code();
    test_lockout();
    test_reset_mid();
    test_lock_with_enter();
`ifdef LOCKER_PROG_EN
    test_prog();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
